// File: rtl/frac_arith_pkg.sv
// Shared widths and state encodings for the sign-magnitude fraction
// arithmetic blocks (fraction_multiplier and fraction_divider).
package frac_arith_pkg;

  localparam int FW     = 6;
  localparam int PROD_W = 2 * FW + 1;
  localparam int FRAC_W = FW + 1;
  localparam int CNT_W  = $clog2(FW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fraction_divider_if.sv
// Start/done handshake and operand/result bus of the fraction divider.
interface fraction_divider_if;
  import frac_arith_pkg::*;

  logic              start;
  logic [PROD_W-1:0] n;
  logic [FRAC_W-1:0] d;
  logic              busy;
  logic              done;
  logic [FRAC_W-1:0] q;
  logic [FW-1:0]     rem;
  logic              ovf;

  modport master (output start, n, d, input busy, done, q, rem, ovf);
  modport slave  (input start, n, d, output busy, done, q, rem, ovf);
endinterface

// File: rtl/frac_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and emit one quotient bit.
module frac_div_step
  import frac_arith_pkg::*;
(
  input  logic [FW-1:0] p_i,
  input  logic          bit_i,
  input  logic [FW-1:0] d_i,
  output logic [FW-1:0] p_o,
  output logic          qbit_o
);

  logic [FW:0] pp_s;

  // Partial remainder stays below D, so the difference always fits in FW bits.
  always_comb begin
    pp_s = {p_i, bit_i};
    if (pp_s >= {1'b0, d_i}) begin
      p_o    = pp_s[FW-1:0] - d_i;
      qbit_o = 1'b1;
    end else begin
      p_o    = pp_s[FW-1:0];
      qbit_o = 1'b0;
    end
  end

endmodule

// File: rtl/fraction_divider.sv
// Sequential restoring divider for sign-magnitude fractions, one quotient bit
// per cycle. Define FRACTION_DIVIDER_ROUND_EN for round-half-up quotients.
module fraction_divider
  import frac_arith_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  fraction_divider_if.slave  bus
);

  state_e            state_q, state_d;
  logic [FW-1:0]     p_q, p_d;
  logic [FW-1:0]     sh_q, sh_d;
  logic [FW-1:0]     quo_q, quo_d;
  logic [FW-1:0]     div_q, div_d;
  logic              sgn_q, sgn_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] q_q, q_d;
  logic [FW-1:0]     rem_q, rem_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              accept_s;
  logic              ovf_chk_s;
  logic [FW-1:0]     step_p_s;
  logic              step_qbit_s;
  logic [FW-1:0]     quo_full_s;
  logic [FW-1:0]     quo_fin_s;

  frac_div_step u_step (
    .p_i    (p_q),
    .bit_i  (sh_q[FW-1]),
    .d_i    (div_q),
    .p_o    (step_p_s),
    .qbit_o (step_qbit_s)
  );

  assign accept_s   = bus.start && (state_q != RUN);
  assign ovf_chk_s  = (bus.d[FW-1:0] == {FW{1'b0}}) ||
                      (bus.n[2*FW-1:FW] >= bus.d[FW-1:0]);
  assign quo_full_s = {quo_q[FW-2:0], step_qbit_s};

`ifdef FRACTION_DIVIDER_ROUND_EN
  // Round half up on the final remainder; an all-ones quotient saturates.
  always_comb begin
    if (({step_p_s, 1'b0} >= {1'b0, div_q}) && (quo_full_s != {FW{1'b1}})) begin
      quo_fin_s = quo_full_s + {{(FW-1){1'b0}}, 1'b1};
    end else begin
      quo_fin_s = quo_full_s;
    end
  end
`else
  assign quo_fin_s = quo_full_s;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    sh_d    = sh_q;
    quo_d   = quo_q;
    div_d   = div_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    done_d  = done_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          div_d  = bus.d[FW-1:0];
          sgn_d  = bus.n[2*FW] ^ bus.d[FW];
          p_d    = bus.n[2*FW-1:FW];
          sh_d   = bus.n[FW-1:0];
          quo_d  = {FW{1'b0}};
          cnt_d  = CNT_W'(FW);
          done_d = 1'b0;
          if (ovf_chk_s) begin
            state_d = DONE;
            q_d     = {bus.n[2*FW] ^ bus.d[FW], {FW{1'b1}}};
            rem_d   = {FW{1'b0}};
            ovf_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        p_d   = step_p_s;
        sh_d  = {sh_q[FW-2:0], 1'b0};
        quo_d = quo_full_s;
        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ovf_d   = 1'b0;
          q_d     = {sgn_q && (quo_fin_s != {FW{1'b0}}), quo_fin_s};
          rem_d   = step_p_s;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= {FW{1'b0}};
      sh_q    <= {FW{1'b0}};
      quo_q   <= {FW{1'b0}};
      div_q   <= {FW{1'b0}};
      sgn_q   <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      q_q     <= {FRAC_W{1'b0}};
      rem_q   <= {FW{1'b0}};
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      sh_q    <= sh_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.q    = q_q;
  assign bus.rem  = rem_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_fraction_divider.sv
// Scoreboard bench for fraction_divider; honours FRACTION_DIVIDER_ROUND_EN.
module tb_fraction_divider;

  typedef struct {
    logic [6:0] q;
    logic [5:0] rem;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  fraction_divider_if bus ();

  fraction_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [12:0] nn, input logic [6:0] dd);
    exp_t e;
    int   nm, dm, qm, rm;
    logic s;
    nm = int'(nn[11:0]);
    dm = int'(dd[5:0]);
    s  = nn[12] ^ dd[6];
    if (dm == 0 || (nm / 64) >= dm) begin
      e.q   = {s, 6'h3f};
      e.rem = 6'd0;
      e.ovf = 1'b1;
    end else begin
      qm = nm / dm;
      rm = nm % dm;
`ifdef FRACTION_DIVIDER_ROUND_EN
      if (2 * rm >= dm && qm < 63) qm = qm + 1;
`endif
      e.q   = {(qm != 0) ? s : 1'b0, 6'(qm)};
      e.rem = 6'(rm);
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Drive one start pulse; returns just after the accepting edge.
  task automatic issue(input logic [12:0] nn, input logic [6:0] dd);
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = nn;
    bus.d     = dd;
    sb.push_back(model(nn, dd));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Wait for done (edges already elapsed since start given), then score.
  task automatic wait_result(input int already);
    int   lat;
    exp_t e;
    lat = already;
    while (!bus.done && lat < 20) begin
      check_eq("busy_run", 32'(bus.busy), 32'd1);
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("done", 32'(bus.done), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("latency", 32'(lat), e.ovf ? 32'd1 : 32'd7);
      check_eq("q", 32'(bus.q), 32'(e.q));
      check_eq("rem", 32'(bus.rem), 32'(e.rem));
      check_eq("ovf", 32'(bus.ovf), 32'(e.ovf));
      check_eq("busy_done", 32'(bus.busy), 32'd0);
    end else begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
    check_eq({tag, "_q"}, 32'(bus.q), 32'd0);
    check_eq({tag, "_rem"}, 32'(bus.rem), 32'd0);
    check_eq({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.n     = 13'd0;
    bus.d     = 7'd0;
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases: exact, negative, overflow, divide-by-zero, small/rounding.
    issue(13'b0_110100100011, 7'b0111001); wait_result(1);
    issue(13'b1_110100100011, 7'b0111001); wait_result(1);
    issue(13'b0_100000000000, 7'b0100000); wait_result(1);
    issue(13'b0_000000000001, 7'b1000000); wait_result(1);
    issue(13'b1_000000000101, 7'b0000111); wait_result(1);
    issue(13'b0_000000111111, 7'b0000001); wait_result(1);
    issue(13'b1_111110111111, 7'b1111111); wait_result(1);

    // Start during RUN is ignored.
    issue(13'b0_110100100011, 7'b0111001);
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = 13'b0_000011110000;
    bus.d     = 7'b0000011;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    wait_result(3);

    // New start while in DONE drops done on the accepting edge.
    issue(13'b1_001100110011, 7'b0101010);
    check_eq("done_drop", 32'(bus.done), 32'd0);
    wait_result(1);

    // Reset mid-run aborts immediately.
    issue(13'b0_110100100011, 7'b0111001);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    issue(13'b0_110100100011, 7'b0111001); wait_result(1);

    // Random operands.
    for (int i = 0; i < 12; i++) begin
      logic [12:0] rn;
      logic [6:0]  rd;
      rn = 13'($urandom);
      rd = 7'($urandom);
      if (i % 2 == 0) rn[11:6] = 6'($urandom_range(0, 3));
      issue(rn, rd);
      wait_result(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
